// File: rtl/sync_fifo_reader_if.sv
// sync_fifo_reader_if: FIFO read port plus valid/ready stream bundle.
// m_last exists only when SYNC_FIFO_READER_LAST_EN is defined.
interface sync_fifo_reader_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_rd_en;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
`ifdef SYNC_FIFO_READER_LAST_EN
  logic             m_last;
`endif

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
`ifdef SYNC_FIFO_READER_LAST_EN
    ,
    output m_last
`endif
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
`ifdef SYNC_FIFO_READER_LAST_EN
    ,
    input  m_last
`endif
  );
endinterface

// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader: pops a registered-read FIFO into a 2-entry stream buffer.
// Define SYNC_FIFO_READER_LAST_EN to add PKT_LEN framing on m_last.
module sync_fifo_reader #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
`ifdef SYNC_FIFO_READER_LAST_EN
  ,
  parameter int PKT_LEN   = 4
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sync_fifo_reader_if.master   bus,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic                 busy
);

  logic [WIDTH-1:0]     buf_q [2];
  logic [WIDTH-1:0]     buf_d [2];
  logic                 head_q;
  logic                 head_d;
  logic                 tail_q;
  logic                 tail_d;
  logic [1:0]           occ_q;
  logic [1:0]           occ_d;
  logic                 inflight_q;
  logic                 inflight_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  logic                 valid;
  logic                 pop;
  logic                 rd_en;
  logic [2:0]           level;

  assign valid = (occ_q != 2'd0);
  assign pop   = valid && bus.m_ready;

  // Words owned after this edge: buffered + arriving - leaving.
  assign level = {1'b0, occ_q}
               + {2'b00, inflight_q}
               - {2'b00, pop};

  // Strobe only when the FIFO has data and a buffer slot is guaranteed.
  assign rd_en = reset_n
              && !bus.fifo_empty
              && (level < 3'd2);

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_data     = buf_q[head_q];
  assign rd_count       = cnt_q;
  assign busy           = valid || inflight_q;

  // Buffer capture/drain and pointer bookkeeping.
  always_comb begin
    buf_d      = buf_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = rd_en;
    cnt_d      = cnt_q;
    occ_d      = 2'(level);
    if (inflight_q) begin
      buf_d[tail_q] = bus.fifo_rdata;
      tail_d        = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // State registers; any word in flight at reset is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      buf_q      <= buf_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef SYNC_FIFO_READER_LAST_EN
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT =
    CNT_WIDTH'(PKT_LEN - 1);

  logic [CNT_WIDTH-1:0] beat_q;
  logic [CNT_WIDTH-1:0] beat_d;

  // Beat position within the packet, advanced per delivered word.
  always_comb begin
    beat_d = beat_q;
    if (pop) begin
      if (beat_q == LAST_BEAT) begin
        beat_d = '0;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  // Beat register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign bus.m_last = valid && (beat_q == LAST_BEAT);
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// tb_sync_fifo_reader: directed bench with FIFO model and stream scoreboard.
// Build with SYNC_FIFO_READER_LAST_EN to also check m_last framing.
module tb_sync_fifo_reader;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CW-1:0] rd_count;
  logic          busy;

  sync_fifo_reader_if #(.WIDTH(W)) bus ();

  sync_fifo_reader #(
    .WIDTH(W),
    .CNT_WIDTH(CW)
`ifdef SYNC_FIFO_READER_LAST_EN
    ,
    .PKT_LEN(PL)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .rd_count(rd_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q [$];

  // FIFO model: registered read, pointers flushed by reset.
  logic [W-1:0] mem [256];
  logic [7:0]   wp = 8'd0;
  logic [7:0]   rp = 8'd0;
  int           issued = 0;

  assign bus.fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (!reset_n) begin
      rp     <= wp;
      issued <= 0;
    end else if (bus.fifo_rd_en && (wp != rp)) begin
      bus.fifo_rdata <= mem[rp];
      rp             <= rp + 8'd1;
      issued         <= issued + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] d);
    mem[wp] = d;
    wp      = wp + 8'd1;
    exp_q.push_back(d);
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(tag, 32'(n < max), 32'd1);
  endtask

  // Stream monitor: scoreboard, no-empty-read, occupancy, stability.
  int           delivered = 0;
  int           beat = 0;
  int           lasts = 0;
  logic         prev_v = 1'b0;
  logic         prev_r = 1'b0;
  logic [W-1:0] prev_d = '0;
  logic [W-1:0] e;

  always @(negedge clk) begin
    if (!reset_n) begin
      delivered = 0;
      beat      = 0;
      prev_v    = 1'b0;
    end else begin
      chk("rd_en_while_empty",
          32'(bus.fifo_rd_en && bus.fifo_empty), 32'd0);
      chk("outstanding_le_2",
          32'((issued - delivered) <= 2), 32'd1);
      if (prev_v && !prev_r) begin
        chk("hold_valid", 32'(bus.m_valid), 32'd1);
        chk("hold_data", 32'(bus.m_data), 32'(prev_d));
      end
`ifdef SYNC_FIFO_READER_LAST_EN
      chk("m_last",
          32'(bus.m_last),
          32'(bus.m_valid && (beat == PL - 1)));
`endif
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("data", 32'(bus.m_data), 32'(e));
        end
`ifdef SYNC_FIFO_READER_LAST_EN
        if (bus.m_last) lasts++;
`endif
        beat = (beat + 1) % PL;
        delivered++;
      end
      prev_v = bus.m_valid;
      prev_r = bus.m_ready;
      prev_d = bus.m_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [5:0]   en_s;
  logic [5:0]   v_s;
  logic [W-1:0] d_s [6];
  int           cnt_a;
  int           cnt_b;
  int           cnt_c;

  initial begin
    bus.m_ready = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
`ifdef SYNC_FIFO_READER_LAST_EN
    chk("rst_m_last", 32'(bus.m_last), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Three words, continuous ready: timing and latency.
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    load(8'h11);
    load(8'h22);
    load(8'h33);
    #1;
    for (int k = 0; k < 6; k++) begin
      en_s[k] = bus.fifo_rd_en;
      v_s[k]  = bus.m_valid;
      d_s[k]  = bus.m_data;
      if (k < 5) begin
        @(posedge clk);
        #2;
      end
    end
    chk("t1_rd_en_pattern", 32'(en_s), 32'h07);
    chk("t1_valid_pattern", 32'(v_s), 32'h1c);
    chk("t1_data0", 32'(d_s[2]), 32'h11);
    chk("t1_data1", 32'(d_s[3]), 32'h22);
    chk("t1_data2", 32'(d_s[4]), 32'h33);
    chk("t1_rd_count", 32'(rd_count), 32'd3);
    chk("t1_busy", 32'(busy), 32'd0);

    // Empty FIFO, ready held: nothing happens.
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #2;
      cnt_a += int'(bus.fifo_rd_en);
      cnt_b += int'(bus.m_valid);
      cnt_c += int'(busy);
    end
    chk("t2_rd_en", 32'(cnt_a), 32'd0);
    chk("t2_valid", 32'(cnt_b), 32'd0);
    chk("t2_busy", 32'(cnt_c), 32'd0);

    // Backpressure: five words, ready low for 8 cycles.
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(8'hA1 + 8'(i));
    #1;
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 8; k++) begin
      cnt_a += int'(bus.fifo_rd_en);
      if (k >= 2 && !(bus.m_valid && bus.m_data == 8'hA1))
        cnt_b++;
      @(posedge clk);
      #2;
    end
    chk("t3_strobes", 32'(cnt_a), 32'd2);
    chk("t3_hold_first", 32'(cnt_b), 32'd0);
    chk("t3_m_data", 32'(bus.m_data), 32'hA1);
    bus.m_ready = 1'b1;
    wait_drain("t3_drain_timeout", 40);
    chk("t3_rd_count", 32'(rd_count), 32'd8);

    // Alternating ready with eight words.
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) load(8'h40 + 8'(i));
    cnt_a = 0;
    while ((exp_q.size() != 0 || busy) && cnt_a < 80) begin
      @(posedge clk);
      #1;
      bus.m_ready = ~bus.m_ready;
      cnt_a++;
    end
    chk("t4_drain_timeout", 32'(cnt_a < 80), 32'd1);
    bus.m_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("t4_rd_count_wrap", 32'(rd_count), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);

    // Eight-word stream for framing.
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) load(8'h50 + 8'(i));
    wait_drain("t5_drain_timeout", 40);
    chk("t5_rd_count", 32'(rd_count), 32'd8);
`ifdef SYNC_FIFO_READER_LAST_EN
    chk("t5_last_total", 32'(lasts), 32'd6);
`endif

    // Asynchronous reset with a word in flight.
    @(posedge clk);
    #1;
    load(8'h60);
    load(8'h61);
    load(8'h62);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("t6_pre_valid", 32'(bus.m_valid), 32'd1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_m_valid", 32'(bus.m_valid), 32'd0);
    chk("t6_rd_count", 32'(rd_count), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    @(posedge clk);
    #2;
    chk("t6_rd_en_hold", 32'(bus.fifo_rd_en), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    load(8'h70);
    load(8'h71);
    wait_drain("t6_drain_timeout", 40);
    chk("t6_post_count", 32'(rd_count), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
